truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Sequencer that characterises one N_IN-input combinational logic circuit (e.g. a 3-input gate 0xCE).
//  Walks all 2^N_IN input rows, holds each row for SETTLE_CYCLES, samples the circuit output, builds the
//  measured truth table and compares it with an expected table. Sits between the test controller and the DUT.
// PARAMETERS
//  N_IN           3   number of circuit inputs; table width TT_W = 2**N_IN
//  SETTLE_CYCLES  4   cycles each row is held before sampling; legal range >= SYNC_STAGES+1
//  SYNC_STAGES    2   synchroniser depth on dut_out; legal range >= 1
// PORTS
//  clk       in   1      single clock, rising edge
//  rst       in   1      synchronous, active-high reset
//  start     in   1      request sweep; accepted only in IDLE
//  abort     in   1      cancel a sweep in progress
//  exp_tt    in   TT_W   expected table; captured when start is accepted
//  dut_out   in   1      output of circuit under test (asynchronous)
//  dut_in    out  N_IN   row applied to circuit, MSB = in1
//  busy      out  1      high from accept until the end of REPORT
//  done      out  1      one-cycle pulse in REPORT
//  pass      out  1      measured == expected; valid while done=1 and held afterwards
//  meas_tt   out  TT_W   measured table
//  err_mask  out  TT_W   meas_tt ^ expected; 1 = mismatching row
// BEHAVIOUR
//  - Table bit order: meas_tt[TT_W-1-row] = output for row, so rows 000..111 read MSB->LSB (0xCE naming).
//  - Reset: state=IDLE; dut_in, busy, done, pass, meas_tt, err_mask, row, cnt, exp_q and sync flops all 0.
//  - dut_out passes through a SYNC_STAGES flop synchroniser before it is sampled.
//  - IDLE: busy=0, dut_in=0. start=1 -> exp_q<=exp_tt, meas_tt<=0, err_mask<=0, pass<=0, row<=0,
//    cnt<=SETTLE_CYCLES-1, go to SETTLE.
//  - SETTLE: busy=1, dut_in=row. Each cycle cnt--. At cnt==0, load the synchronised dut_out into
//    meas_tt[TT_W-1-row].
//    If row==TT_W-1 -> REPORT; else row++ and cnt<=SETTLE_CYCLES-1.
//  - REPORT (1 cycle): busy=1, done=1, pass=(meas_tt==exp_q), err_mask=meas_tt^exp_q; then go to IDLE,
//    dut_in<=0.
//  - Latency: start accepted at edge 0, SETTLE spans cycles 1..TT_W*SETTLE_CYCLES,
//    done in cycle TT_W*SETTLE_CYCLES+1 (33 with defaults).
//  - abort in SETTLE -> IDLE next cycle, dut_in<=0, no done pulse.
//    Partial meas_tt is kept; pass stays 0 and err_mask stays 0.
//  - abort has priority over the sample/advance step in the same cycle. abort in IDLE or REPORT is ignored.
//  - start while busy is ignored. start in the REPORT cycle is ignored; a new start is needed in IDLE.
//    abort and start both high in IDLE: start wins.
//  - exp_tt changes after accept have no effect. Results hold until the next accepted start.
//  - rst high at any time overrides everything: back to the reset state in the next cycle.
//  - Widths: row is N_IN bits and increments without wrap, because REPORT exits first;
//    cnt is $clog2(SETTLE_CYCLES+1) bits.
// STRUCTURE
//  - Package tt_sweep_pkg: state enum {IDLE, SETTLE, REPORT}; function tt_bit_idx(row, n_in) = 2**n_in-1-row.
//  - Sub-module sync_ff #(.STAGES(SYNC_STAGES)): the dut_out synchroniser.
//  - Main block: FSM, row/cnt counters, table registers.
// TESTING
//  1. DUT model = 0xCE gate, exp_tt=8'hCE, start pulse -> dut_in goes 0..7 holding 4 cycles each;
//     done in cycle 33; pass=1, meas_tt=8'hCE, err_mask=0.
//  2. Same DUT, exp_tt=8'hCF -> pass=0, err_mask=8'h01 (row 111 mismatches), meas_tt=8'hCE.
//  3. DUT tied to 1 -> meas_tt=8'hFF. DUT tied to 0 -> meas_tt=8'h00.
//     Each run: exactly one done pulse and busy high for 33 cycles.
//  4. abort in cycle 10 -> busy=0 in cycle 11, no done, dut_in=0, pass=0.
//     Then start -> a full sweep completes correctly.
//  5. start re-pulsed in cycles 5 and 33 (REPORT) -> ignored: a single sweep with a single done.
//     exp_tt changed mid-sweep -> no effect on pass.
//  6. rst asserted mid-SETTLE for 1 cycle -> next cycle all outputs 0, state IDLE.
//     Also SETTLE_CYCLES=3 build: done in cycle 25.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package tt_sweep_pkg;

    // Sweeper sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    // Table bit that holds the result for a given input row; row 0 lands in the MSB
    // so the table reads like the usual gate number (e.g. 0xCE).
    function automatic int unsigned tt_bit_idx(input int unsigned row, input int unsigned n_in);
        return (2 ** n_in) - 1 - row;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_sync.sv
// Multi-flop synchroniser for the asynchronous circuit output.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the input through STAGES flops; the oldest sample is the output
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= STAGES'({sync_q, d_i});
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input row of a small combinational circuit, samples its output
// after a settle interval and compares the measured truth table with an
// expected one captured at start.
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   exp_tt,
    input  logic                 dut_out,
    output logic [N_IN-1:0]      dut_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   meas_tt,
    output logic [2**N_IN-1:0]   err_mask
);

    localparam int TT_W  = 2 ** N_IN;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]  LAST_ROW   = N_IN'(TT_W - 1);

    state_e              state_q, state_d;
    logic [N_IN-1:0]     row_q, row_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TT_W-1:0]     exp_q, exp_d;
    logic [TT_W-1:0]     meas_q, meas_d;
    logic [TT_W-1:0]     err_q, err_d;
    logic                pass_q, pass_d;
    logic                dut_sync;
    logic [N_IN-1:0]     bit_idx;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (dut_out),
        .q_o (dut_sync)
    );

    assign bit_idx = N_IN'(tt_bit_idx(32'(row_q), N_IN));

    // Next-state logic: accept, settle/sample/advance per row, then report.
    // pass/err_mask are computed on the final sample so they are already
    // valid during the single REPORT cycle.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        meas_d  = meas_q;
        err_d   = err_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_d   = exp_tt;
                    meas_d  = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    row_d   = '0;
                    cnt_d   = CNT_RELOAD;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    meas_d[bit_idx] = dut_sync;
                    if (row_q == LAST_ROW) begin
                        state_d = ST_REPORT;
                        pass_d  = (meas_d == exp_q);
                        err_d   = meas_d ^ exp_q;
                    end else begin
                        row_d = row_q + N_IN'(1);
                        cnt_d = CNT_RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            meas_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            meas_q  <= meas_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    assign dut_in   = (state_q == ST_SETTLE) ? row_q : '0;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_REPORT);
    assign pass     = pass_q;
    assign meas_tt  = meas_q;
    assign err_mask = err_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: stimulus pushes expected sweep
// results, monitors pop and compare on each done pulse.
module tb_truth_table_sweeper;

    typedef struct {
        logic [7:0] meas;
        logic [7:0] err;
        logic       pass;
        int         lat;
        int         busy_len;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, start3;
    logic [7:0] exp_tt, exp_tt3;
    logic [7:0] model_tt;
    logic       dut_out, dut_out3;
    logic [2:0] dut_in, dut_in3;
    logic       busy, done, pass, busy3, done3, pass3;
    logic [7:0] meas_tt, err_mask, meas_tt3, err_mask3;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;
    int t0_3 = 0;
    int busy_cnt = 0;
    int busy_cnt3 = 0;
    exp_t sb[$];
    exp_t sb3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Circuit under test: arbitrary truth table, row 0 in the MSB
    assign dut_out  = model_tt[3'd7 - dut_in];
    assign dut_out3 = model_tt[3'd7 - dut_in3];

    truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(4), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .exp_tt(exp_tt),
        .dut_out(dut_out), .dut_in(dut_in), .busy(busy), .done(done), .pass(pass),
        .meas_tt(meas_tt), .err_mask(err_mask)
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(3), .SYNC_STAGES(2)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(1'b0), .exp_tt(exp_tt3),
        .dut_out(dut_out3), .dut_in(dut_in3), .busy(busy3), .done(done3), .pass(pass3),
        .meas_tt(meas_tt3), .err_mask(err_mask3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor for the default build
    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_cnt++; else busy_cnt = 0;
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("meas_tt", 32'(meas_tt), 32'(e.meas));
                chk("err_mask", 32'(err_mask), 32'(e.err));
                chk("pass", 32'(pass), 32'(e.pass));
                chk("done_latency", 32'(cyc - t0), 32'(e.lat));
                chk("busy_len", 32'(busy_cnt), 32'(e.busy_len));
            end
        end
    end

    // Monitor for the SETTLE_CYCLES=3 build
    always @(negedge clk) begin
        exp_t e;
        if (busy3) busy_cnt3++; else busy_cnt3 = 0;
        if (done3) begin
            if (sb3.size() == 0) begin
                chk("unexpected_done3", 32'd1, 32'd0);
            end else begin
                e = sb3.pop_front();
                chk("meas_tt3", 32'(meas_tt3), 32'(e.meas));
                chk("err_mask3", 32'(err_mask3), 32'(e.err));
                chk("pass3", 32'(pass3), 32'(e.pass));
                chk("done_latency3", 32'(cyc - t0_3), 32'(e.lat));
                chk("busy_len3", 32'(busy_cnt3), 32'(e.busy_len));
            end
        end
    end

    // Pulse start for one edge; returns at the negedge of cycle 1
    task automatic start_sweep(input logic [7:0] expv);
        @(negedge clk);
        start  = 1'b1;
        exp_tt = expv;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic push(input logic [7:0] m, input logic [7:0] e);
        exp_t x;
        x.meas = m; x.err = m ^ e; x.pass = (m == e); x.lat = 32; x.busy_len = 33;
        sb.push_back(x);
    endtask

    task automatic wait_sweep_end(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) return;
        end
        chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        exp_t x3;
        rst = 1'b1; start = 1'b0; abort = 1'b0; start3 = 1'b0;
        exp_tt = 8'h00; exp_tt3 = 8'h00; model_tt = 8'hCE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_dut_in", 32'(dut_in), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_meas", 32'(meas_tt), 0);
        chk("rst_err", 32'(err_mask), 0);

        // 1: 0xCE gate, matching expectation
        push(8'hCE, 8'hCE);
        start_sweep(8'hCE);
        chk("row0_dut_in", 32'(dut_in), 0);
        repeat (4) @(negedge clk);
        chk("row1_dut_in", 32'(dut_in), 1);
        repeat (12) @(negedge clk);
        chk("row4_dut_in", 32'(dut_in), 4);
        wait_sweep_end("t1");
        repeat (3) @(negedge clk);
        chk("pass_held", 32'(pass), 1);
        chk("meas_held", 32'(meas_tt), 32'h CE);
        chk("idle_dut_in", 32'(dut_in), 0);

        // 2: expectation differs in row 111
        push(8'hCE, 8'hCF);
        start_sweep(8'hCF);
        wait_sweep_end("t2");

        // 3: constant circuits
        model_tt = 8'hFF;
        push(8'hFF, 8'hCE);
        start_sweep(8'hCE);
        wait_sweep_end("t3a");
        model_tt = 8'h00;
        push(8'h00, 8'h00);
        start_sweep(8'h00);
        wait_sweep_end("t3b");

        // 4: abort in cycle 10, rows 0 and 1 already sampled
        model_tt = 8'hCE;
        start_sweep(8'hCE);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_dut_in", 32'(dut_in), 0);
        chk("abort_pass", 32'(pass), 0);
        chk("abort_err", 32'(err_mask), 0);
        chk("abort_meas", 32'(meas_tt), 32'h C0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        push(8'hCE, 8'hCE);
        start_sweep(8'hCE);
        wait_sweep_end("t4");

        // 5: start re-pulsed in cycle 5 and in REPORT; exp_tt changed mid-sweep
        push(8'hCE, 8'hCE);
        start_sweep(8'hCE);
        repeat (4) @(negedge clk);
        start = 1'b1; exp_tt = 8'h00;
        @(negedge clk);
        start = 1'b0;
        repeat (27) @(negedge clk);
        chk("t5_done_cycle33", 32'(done), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_no_restart", 32'(busy), 0);

        // 6: reset mid-SETTLE
        start_sweep(8'hCE);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_done", 32'(done), 0);
        chk("mrst_dut_in", 32'(dut_in), 0);
        chk("mrst_pass", 32'(pass), 0);
        chk("mrst_meas", 32'(meas_tt), 0);
        chk("mrst_err", 32'(err_mask), 0);
        repeat (4) @(negedge clk);
        chk("mrst_idle", 32'(busy), 0);

        // SETTLE_CYCLES=3 build: done in cycle 25
        x3.meas = 8'hCE; x3.err = 8'h00; x3.pass = 1'b1; x3.lat = 24; x3.busy_len = 25;
        sb3.push_back(x3);
        @(negedge clk);
        start3 = 1'b1; exp_tt3 = 8'hCE;
        @(negedge clk);
        start3 = 1'b0;
        t0_3 = cyc;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy3 && sb3.size() == 0) break;
        end

        chk("sb_empty", 32'(sb.size()), 0);
        chk("sb3_empty", 32'(sb3.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
